// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, RGB24 type and clog2 helper shared by the VGA engine
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 2;

    typedef logic [23:0] rgb_t;

    // Smallest w with 2**w >= v; returns at least 1 so ports never collapse to zero width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel-enable divider, scan counters and raw active/sync decode
//   sys_clk, rst_n, enable : clock, asynchronous active-low reset, run enable
//   pix_en, frame_start    : one-cycle strobe per pixel, and the strobe at (0,0)
//   hcount, vcount         : current scan coordinate
//   active, hs, vs         : raw decode of the current coordinate, sync active-high
//   vga_clk_d              : level the registered panel clock takes on the next edge
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = clog2(H_TOTAL),
    localparam int VW      = clog2(V_TOTAL),
    localparam int DW      = clog2(CLK_DIV)
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          pix_en,
    output logic          frame_start,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          vga_clk_d
);

    logic [DW-1:0] div;
    logic [DW-1:0] div_n;
    logic          h_last;
    logic          v_last;

    assign pix_en      = enable && div == DW'(CLK_DIV - 1);
    assign div_n       = (!enable || pix_en) ? '0 : div + 1'b1;
    // Registering the next-cycle level puts the panel clock's rising edge mid-way through the held pixel.
    assign vga_clk_d   = div_n >= DW'(CLK_DIV / 2);
    assign h_last      = hcount == HW'(H_TOTAL - 1);
    assign v_last      = vcount == VW'(V_TOTAL - 1);
    assign frame_start = pix_en && hcount == '0 && vcount == '0;
    assign active      = hcount < HW'(H_ACTIVE) && vcount < VW'(V_ACTIVE);
    assign hs          = hcount >= HW'(H_ACTIVE + H_FP) && hcount < HW'(H_ACTIVE + H_FP + H_SYNC);
    assign vs          = vcount >= VW'(V_ACTIVE + V_FP) && vcount < VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div <= div_n;
            if (!enable) begin
                hcount <= '0;
                vcount <= '0;
            end else if (pix_en) begin
                hcount <= h_last ? '0 : hcount + 1'b1;
                if (h_last)
                    vcount <= v_last ? '0 : vcount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_compositor.sv
// vga_compositor: programmable VGA timing with layered priority compositing onto registered panel outputs
//   sys_clk, rst_n, enable          : clock, asynchronous active-low reset, run enable
//   bg_rgb                          : background colour {R,G,B}
//   layer_rgb, layer_opaque         : per-layer colour (layer i at [24i+23:24i]) and coverage
//   pix_en, hcount, vcount          : pixel strobe and scan coordinate for the layer generators
//   frame_start                     : pix_en-qualified strobe at (0,0)
//   VGA_HS/VS/BLANK_N/CLK/SYNC_N    : registered panel timing
//   VGA_R/G/B                       : registered panel colour
module vga_compositor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int NUM_LAYERS = 3,
    parameter int LAYER_LAT  = 2,
    localparam int HW        = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW        = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  rgb_t                     bg_rgb,
    input  logic [24*NUM_LAYERS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]    layer_opaque,
    output logic                     pix_en,
    output logic [HW-1:0]            hcount,
    output logic [VW-1:0]            vcount,
    output logic                     frame_start,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic                     VGA_BLANK_N,
    output logic                     VGA_CLK,
    output logic                     VGA_SYNC_N,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B
);

    logic [2:0] raw;
    logic [2:0] dly;
    logic       active;
    logic       hs;
    logic       vs;
    logic       vga_clk_d;
    rgb_t       pick;
    rgb_t       rgb_q;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_core (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .hs          (hs),
        .vs          (vs),
        .vga_clk_d   (vga_clk_d)
    );

    assign raw = {active, hs, vs};

    // Timing signals wait LAYER_LAT pixels so they meet the layer data of the same coordinate.
    // Not cleared at line/frame wrap, so sync and blank stay continuous across boundaries.
    generate
        if (LAYER_LAT == 0) begin : g_nodly
            assign dly = raw;
        end else begin : g_dly
            logic [2:0] sr [LAYER_LAT];
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAYER_LAT; i++) sr[i] <= '0;
                end else if (!enable) begin
                    for (int i = 0; i < LAYER_LAT; i++) sr[i] <= '0;
                end else if (pix_en) begin
                    sr[0] <= raw;
                    for (int i = 1; i < LAYER_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly = sr[LAYER_LAT-1];
        end
    endgenerate

    // Later layers overwrite earlier ones, so the highest-index opaque layer wins.
    always_comb begin
        pick = bg_rgb;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (layer_opaque[i]) pick = layer_rgb[24*i +: 24];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= '0;
            VGA_BLANK_N <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_CLK     <= 1'b0;
        end else begin
            VGA_CLK <= vga_clk_d;
            if (!enable) begin
                rgb_q       <= '0;
                VGA_BLANK_N <= 1'b0;
                VGA_HS      <= ~HS_POL;
                VGA_VS      <= ~VS_POL;
            end else if (pix_en) begin
                rgb_q       <= dly[2] ? pick : '0;
                VGA_BLANK_N <= dly[2];
                VGA_HS      <= dly[1] ^ ~HS_POL;
                VGA_VS      <= dly[0] ^ ~VS_POL;
            end
        end
    end

    assign VGA_SYNC_N = 1'b0;
    assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule
